uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register and sticky overrun/framing flags.
// The line is sampled at mid-bit, counted from a synchronized start-bit falling edge.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_CHECK   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ard_ack,
  output logic [7:0] ard_data,
  output logic       ard_valid,
  output logic       ard_busy,
  output logic       ard_overrun,
  output logic       ard_frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_armed;

  logic        w_rxs;
  logic        w_expired;
  logic        w_deliver;
  logic        w_stop_bad;

  assign w_rxs      = r_sync2;
  assign w_expired  = (r_timer == 16'd0);
  assign w_deliver  = (r_state == STOP) && w_expired;
  assign w_stop_bad = (STOP_CHECK != 0) && !w_rxs;
  assign ard_busy   = (r_state != IDLE);

  // Two-flop synchronizer, preset high so reset never fakes a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM together with the host-facing holding register and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_timer       <= 16'd0;
      r_idx         <= 3'd0;
      r_shift       <= 8'h00;
      r_armed       <= 1'b1;
      ard_data      <= 8'h00;
      ard_valid     <= 1'b0;
      ard_overrun   <= 1'b0;
      ard_frame_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // After a low stop bit the line must return high before re-arming
          if (!r_armed) begin
            if (w_rxs) r_armed <= 1'b1;
          end else if (!w_rxs) begin
            r_state <= START;
            r_timer <= HALF_BIT;
          end
        end
        START: begin
          if (w_expired) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_timer <= FULL_BIT;
              r_idx   <= 3'd0;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        DATA: begin
          if (w_expired) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            r_timer <= FULL_BIT;
            if (r_idx == 3'd7) r_state <= STOP;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        STOP: begin
          if (w_expired) begin
            r_state  <= IDLE;
            ard_data <= r_shift;
            if (w_stop_bad) begin
              ard_frame_err <= 1'b1;
              r_armed       <= 1'b0;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A delivery coinciding with an ack is a clean handover, not an overrun
      if (w_deliver) begin
        ard_valid <= 1'b1;
        if (ard_valid && !ard_ack) ard_overrun <= 1'b1;
      end else if (ard_ack) begin
        ard_valid <= 1'b0;
      end
    end
  end

endmodule
